pipeline_ctrl: RTL and testbench

Hazard and stall controller for the 5-stage RV32I pipeline. It drives the enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, which sequences all instruction movement through the datapath. It handles four events: load-use hazards, taken branches and jumps, instruction-memory wait, and data-memory wait. A data-memory wait that exceeds a timeout halts the pipeline.

---
 rtl/pipeline_ctrl_pkg.sv | 21 ++
 rtl/pipeline_ctrl_hazard_detect.sv | 26 ++
 rtl/pipeline_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg : shared types and widths for the pipeline controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipeline_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam int CNT_W     = 32;
  localparam int WAIT_W    = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect : combinational load-use comparator between ID and EX
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  output logic                 lu
);

  // x0 is hardwired to zero, so a load targeting it never creates a hazard
  assign lu = ex_mem_read && (ex_rd != '0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) ||
               (id_use_rs2 && (id_rs2 == ex_rd)));

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl : stall/flush sequencing for the 5-stage RV32I pipeline
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 ex_branch_taken,
  input  logic                 imem_ready,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 idex_en,
  output logic                 exmem_en,
  output logic                 memwb_en,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 halted,
  output logic                 mem_timeout,
  output logic [CNT_W-1:0]     stall_cycles
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DMEM_TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;
  logic                halted_q, halted_d;
  logic                mem_timeout_q, mem_timeout_d;
  logic                lu;
  logic                dw;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .lu          (lu)
  );

  assign dw = mem_req && !mem_ready;

  // Priority mux: a frozen MEM stage outranks everything, then redirect, then hazards
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if ((state_q == ST_HALT) || dw) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (!imem_ready) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    halted_d       = halted_q;
    mem_timeout_d  = mem_timeout_q;
    stall_cycles_d = pc_en ? stall_cycles_q : stall_cycles_q + 1'b1;
    case (state_q)
      ST_RUN: begin
        wait_cnt_d = '0;
        if (dw) begin
          state_d = ST_DWAIT;
        end
      end
      ST_DWAIT: begin
        if (!dw) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d       = ST_HALT;
            halted_d      = 1'b1;
            mem_timeout_d = 1'b1;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    if (!rst) begin
      state_d        = ST_RUN;
      wait_cnt_d     = '0;
      stall_cycles_d = '0;
      halted_d       = 1'b0;
      mem_timeout_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q        <= state_d;
    wait_cnt_q     <= wait_cnt_d;
    stall_cycles_q <= stall_cycles_d;
    halted_q       <= halted_d;
    mem_timeout_q  <= mem_timeout_d;
  end

  assign halted       = halted_q;
  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl : directed scoreboard bench, three timeout settings (8, 4, 1)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
  logic       imem_ready, mem_req, mem_ready;

  logic [4:0]  en_a, en_b, en_c;
  logic [1:0]  fl_a, fl_b, fl_c;
  logic        hlt_a, hlt_b, hlt_c, mto_a, mto_b, mto_c;
  logic [31:0] stall_a, stall_b, stall_c;

  always #5 clk = ~clk;

  pipeline_ctrl #(.DMEM_TIMEOUT(8)) u_dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .imem_ready(imem_ready), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(en_a[4]), .ifid_en(en_a[3]), .idex_en(en_a[2]), .exmem_en(en_a[1]),
    .memwb_en(en_a[0]), .ifid_flush(fl_a[1]), .idex_flush(fl_a[0]),
    .halted(hlt_a), .mem_timeout(mto_a), .stall_cycles(stall_a)
  );

  pipeline_ctrl #(.DMEM_TIMEOUT(4)) u_dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .imem_ready(imem_ready), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(en_b[4]), .ifid_en(en_b[3]), .idex_en(en_b[2]), .exmem_en(en_b[1]),
    .memwb_en(en_b[0]), .ifid_flush(fl_b[1]), .idex_flush(fl_b[0]),
    .halted(hlt_b), .mem_timeout(mto_b), .stall_cycles(stall_b)
  );

  pipeline_ctrl #(.DMEM_TIMEOUT(1)) u_dut_c (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .imem_ready(imem_ready), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(en_c[4]), .ifid_en(en_c[3]), .idex_en(en_c[2]), .exmem_en(en_c[1]),
    .memwb_en(en_c[0]), .ifid_flush(fl_c[1]), .idex_flush(fl_c[0]),
    .halted(hlt_c), .mem_timeout(mto_c), .stall_cycles(stall_c)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [4:0]  en;
    logic [4:0]  msk;
    logic [1:0]  fl;
    logic        hlt;
    logic        mto;
    logic [31:0] stall;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [4:0]  act_en;
  logic [1:0]  act_fl;
  logic        act_hlt, act_mto;
  logic [31:0] act_stall;

  localparam logic [4:0] ALL = 5'b11111;
  localparam logic [4:0] NO_IDEX = 5'b11011;

  // Monitor: compares every queued expectation against the selected DUT
  always @(negedge clk) begin
    while (q.size() != 0) begin
      mon_e = q.pop_front();
      case (mon_e.sel)
        0:       begin act_en = en_a; act_fl = fl_a; act_hlt = hlt_a; act_mto = mto_a; act_stall = stall_a; end
        1:       begin act_en = en_b; act_fl = fl_b; act_hlt = hlt_b; act_mto = mto_b; act_stall = stall_b; end
        default: begin act_en = en_c; act_fl = fl_c; act_hlt = hlt_c; act_mto = mto_c; act_stall = stall_c; end
      endcase
      n_chk++;
      if (((act_en & mon_e.msk) !== (mon_e.en & mon_e.msk)) || (act_fl !== mon_e.fl) ||
          (act_hlt !== mon_e.hlt) || (act_mto !== mon_e.mto) || (act_stall !== mon_e.stall)) begin
        n_fail++;
        $display("FAIL %s (dut %0d): got en=%b fl=%b halted=%b timeout=%b stall=%0d, want en=%b/mask %b fl=%b halted=%b timeout=%b stall=%0d",
                 mon_e.name, mon_e.sel, act_en, act_fl, act_hlt, act_mto, act_stall,
                 mon_e.en, mon_e.msk, mon_e.fl, mon_e.hlt, mon_e.mto, mon_e.stall);
      end
    end
  end

  task automatic exp_out(input string nm, input int sel, input logic [4:0] en, input logic [4:0] msk,
                         input logic [1:0] fl, input logic hlt, input logic mto, input logic [31:0] stall);
    exp_t e;
    e.name = nm; e.sel = sel; e.en = en; e.msk = msk; e.fl = fl;
    e.hlt = hlt; e.mto = mto; e.stall = stall;
    q.push_back(e);
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    imem_ready = 1'b1; mem_req = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic set_lu();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
  endtask

  task automatic set_dw();
    mem_req = 1'b1; mem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle();
    tick(); tick();

    exp_out("reset_state", 0, ALL, ALL, 2'b00, 0, 0, 0);
    exp_out("reset_state_t1", 2, ALL, ALL, 2'b00, 0, 0, 0);
    tick();
    rst = 1'b1;

    idle(); exp_out("idle", 0, ALL, ALL, 2'b00, 0, 0, 0); tick();
    idle(); set_lu(); exp_out("load_use", 0, 5'b00111, NO_IDEX, 2'b01, 0, 0, 0); tick();
    idle(); exp_out("load_use_done", 0, ALL, ALL, 2'b00, 0, 0, 1); tick();
    idle(); set_lu(); ex_rd = 5'd0; id_rs1 = 5'd0;
    exp_out("x0_immune", 0, ALL, ALL, 2'b00, 0, 0, 1); tick();
    idle(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
    id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    exp_out("load_use_rs2", 0, 5'b00111, NO_IDEX, 2'b01, 0, 0, 1); tick();
    idle(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b0;
    exp_out("rs2_unused", 0, ALL, ALL, 2'b00, 0, 0, 2); tick();
    idle(); set_lu(); ex_branch_taken = 1'b1;
    exp_out("branch_beats_lu", 0, ALL, ALL, 2'b11, 0, 0, 2); tick();
    idle(); exp_out("after_branch", 0, ALL, ALL, 2'b00, 0, 0, 2); tick();
    idle(); imem_ready = 1'b0;
    exp_out("imem_wait", 0, 5'b01111, ALL, 2'b10, 0, 0, 2); tick();
    idle(); imem_ready = 1'b0; ex_branch_taken = 1'b1;
    exp_out("branch_beats_imem", 0, ALL, ALL, 2'b11, 0, 0, 3); tick();
    idle(); imem_ready = 1'b0; set_lu();
    exp_out("lu_beats_imem", 0, 5'b00111, NO_IDEX, 2'b01, 0, 0, 3); tick();
    idle(); exp_out("idle_2", 0, ALL, ALL, 2'b00, 0, 0, 4); tick();

    // Three-cycle data wait; the T=1 instance times out on its second dw cycle
    idle(); set_dw();
    exp_out("dwait_1", 0, 5'b00000, ALL, 2'b00, 0, 0, 4);
    exp_out("t1_dwait_1", 2, 5'b00000, ALL, 2'b00, 0, 0, 4); tick();
    idle(); set_dw(); ex_branch_taken = 1'b1;
    exp_out("dwait_beats_branch", 0, 5'b00000, ALL, 2'b00, 0, 0, 5);
    exp_out("t1_dwait_2", 2, 5'b00000, ALL, 2'b00, 0, 0, 5); tick();
    idle(); set_dw(); set_lu();
    exp_out("dwait_beats_lu", 0, 5'b00000, ALL, 2'b00, 0, 0, 6);
    exp_out("t1_halted", 2, 5'b00000, ALL, 2'b00, 1, 1, 6); tick();
    idle(); mem_req = 1'b1; mem_ready = 1'b1;
    exp_out("dwait_release", 0, ALL, ALL, 2'b00, 0, 0, 7);
    exp_out("t4_dwait_release", 1, ALL, ALL, 2'b00, 0, 0, 7);
    exp_out("t1_stays_halted", 2, 5'b00000, ALL, 2'b00, 1, 1, 7); tick();
    idle();
    exp_out("dwait_stall_count", 0, ALL, ALL, 2'b00, 0, 0, 7);
    exp_out("t1_halt_ignores_inputs", 2, 5'b00000, ALL, 2'b00, 1, 1, 8); tick();

    // Timeout with DMEM_TIMEOUT=4: halts after the fifth consecutive dw cycle
    for (int k = 1; k <= 5; k++) begin
      idle(); set_dw();
      exp_out($sformatf("t4_wait_%0d", k), 1, 5'b00000, ALL, 2'b00, 0, 0, 32'(6 + k));
      tick();
    end
    idle(); set_dw();
    exp_out("t4_halted", 1, 5'b00000, ALL, 2'b00, 1, 1, 12); tick();
    idle(); mem_req = 1'b1; mem_ready = 1'b1; ex_branch_taken = 1'b1;
    exp_out("t4_halt_frozen", 1, 5'b00000, ALL, 2'b00, 1, 1, 13); tick();
    idle(); rst = 1'b0;
    exp_out("t4_halt_in_reset", 1, 5'b00000, ALL, 2'b00, 1, 1, 14); tick();
    rst = 1'b1;
    idle();
    exp_out("t4_after_reset", 1, ALL, ALL, 2'b00, 0, 0, 0);
    exp_out("t1_after_reset", 2, ALL, ALL, 2'b00, 0, 0, 0); tick();

    // Reset two cycles into DWAIT must clear the wait counter
    idle(); set_dw(); exp_out("mid_dwait_1", 1, 5'b00000, ALL, 2'b00, 0, 0, 0); tick();
    idle(); set_dw(); exp_out("mid_dwait_2", 1, 5'b00000, ALL, 2'b00, 0, 0, 1); tick();
    idle(); set_dw(); rst = 1'b0;
    exp_out("mid_dwait_reset", 1, 5'b00000, ALL, 2'b00, 0, 0, 2); tick();
    rst = 1'b1;
    idle(); exp_out("mid_dwait_run", 1, ALL, ALL, 2'b00, 0, 0, 0); tick();
    for (int k = 1; k <= 5; k++) begin
      idle(); set_dw();
      exp_out($sformatf("fresh_wait_%0d", k), 1, 5'b00000, ALL, 2'b00, 0, 0, 32'(k - 1));
      tick();
    end
    idle(); set_dw();
    exp_out("fresh_halted", 1, 5'b00000, ALL, 2'b00, 1, 1, 5); tick();

    idle();
    tick(); tick();
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
